// File: rtl/pg_bank_sequencer.sv
// Walks bank_en toward a loaded target one bit per step, with a settle wait after each change.
// Optional PG_THERMAL_THROTTLE_EN adds thermal_alarm/throttled to inhibit turn-on steps.
module pg_bank_sequencer #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEF_SETTLE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [NUM_BANKS-1:0] target_mask,
    input  logic [CNT_W-1:0]     cfg_settle,
    output logic [NUM_BANKS-1:0] bank_en,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           step_cnt
`ifdef PG_THERMAL_THROTTLE_EN
    ,
    input  logic                 thermal_alarm,
    output logic                 throttled
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SETTLE
    } state_t;

    state_t               state;
    logic [NUM_BANKS-1:0] target_q;
    logic [CNT_W-1:0]     settle_q;
    logic [CNT_W-1:0]     cnt;

    logic                 inhibit;
    logic [NUM_BANKS-1:0] tgt_eff;
    logic [CNT_W-1:0]     settle_eff;
    logic [CNT_W-1:0]     settle_ld;
    logic [NUM_BANKS-1:0] offs;
    logic [NUM_BANKS-1:0] ons;
    logic [NUM_BANKS-1:0] cand;
    logic [NUM_BANKS-1:0] pick;
    logic                 pending;
    logic                 stalled;

`ifdef PG_THERMAL_THROTTLE_EN
    assign inhibit = thermal_alarm;
`else
    assign inhibit = 1'b0;
`endif

    // A load in the same cycle as a decision is already the target that decision sees.
    assign tgt_eff    = load ? target_mask : target_q;
    assign settle_eff = load ? cfg_settle : settle_q;
    assign settle_ld  = (settle_eff == '0) ? CNT_W'(1) : settle_eff;

    // Turn-offs first; within a class the lowest set bit (x & -x) goes first.
    assign offs    = bank_en & ~tgt_eff;
    assign ons     = ~bank_en & tgt_eff & {NUM_BANKS{~inhibit}};
    assign cand    = (offs != '0) ? offs : ons;
    assign pick    = cand & (-cand);
    assign pending = (bank_en != tgt_eff);
    assign stalled = pending && (cand == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bank_en  <= '0;
            target_q <= '0;
            settle_q <= CNT_W'(DEF_SETTLE);
            cnt      <= CNT_W'(1);
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
`ifdef PG_THERMAL_THROTTLE_EN
            throttled <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PG_THERMAL_THROTTLE_EN
            throttled <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (load) begin
                        busy <= (target_mask != bank_en);
                    end else if (pending) begin
                        busy <= 1'b1;
                        if (stalled) begin
                            // Park in a completed settle until turn-ons are allowed again.
                            state <= SETTLE;
                            cnt   <= CNT_W'(1);
`ifdef PG_THERMAL_THROTTLE_EN
                            throttled <= 1'b1;
`endif
                        end else begin
                            state <= STEP;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                STEP: begin
                    busy    <= 1'b1;
                    bank_en <= bank_en ^ pick;
                    cnt     <= settle_ld;
                    state   <= SETTLE;
                    if (pick != '0 && step_cnt != 8'hFF)
                        step_cnt <= step_cnt + 8'd1;
                end
                SETTLE: begin
                    busy <= 1'b1;
                    if (cnt > CNT_W'(1)) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!pending) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (!stalled) begin
                        state <= STEP;
                    end else begin
`ifdef PG_THERMAL_THROTTLE_EN
                        throttled <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            // Load overrides any step increment on the same edge.
            if (load) begin
                target_q <= target_mask;
                settle_q <= cfg_settle;
                step_cnt <= '0;
            end
        end
    end

endmodule
